delay_arbiter: RTL and testbench

Shares one prescaled timebase counter among `N_REQ` requesters that each need a timed interval, such as LED blink phases or debounce windows. Grants one requester at a time in round-robin order. Counts that requester's duration in prescaled ticks, then pulses `done` for it. Sits between the board clock and the slow-timing consumers, replacing per-consumer free-running dividers.

---
 rtl/delay_arbiter_pkg.sv | 15 +
 rtl/delay_arbiter_rr_pick.sv | 33 +++
 rtl/delay_arbiter.sv | 136 +++++++++++++
 tb/tb_delay_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_arbiter_pkg.sv
// Shared constants and FSM state encoding for the delay_arbiter timebase sharer.
package delay_arbiter_pkg;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_DUR_W    = 16;
    localparam int DEF_PRESCALE = 25_000_000;
    localparam int PRESCALE_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/delay_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request bit after the previous
// owner index, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] win,
    output logic [IDX_W-1:0] win_idx
);

    logic             w_found;
    logic [IDX_W-1:0] w_cand;

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        win     = '0;
        win_idx = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = IDX_W'((int'(last) + k) % N_REQ);
            if (!w_found && req[w_cand]) begin
                w_found      = 1'b1;
                win[w_cand]  = 1'b1;
                win_idx      = w_cand;
            end
        end
    end

endmodule

// File: rtl/delay_arbiter.sv
// Shares one prescaled timebase among N_REQ requesters in round-robin order,
// counting each owner's duration in ticks and pulsing done on completion.
module delay_arbiter
    import delay_arbiter_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int DUR_W    = DEF_DUR_W,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*DUR_W-1:0] dur,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   tick,
    output logic                   busy
);

    localparam int                    IDX_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]      LAST_RESET    = IDX_W'(N_REQ - 1);

    state_t                r_state,     w_state_nxt;
    logic [PRESCALE_W-1:0] r_prescale,  w_prescale_nxt;
    logic [DUR_W-1:0]      r_remaining, w_remaining_nxt;
    logic [IDX_W-1:0]      r_last,      w_last_nxt;
    logic [N_REQ-1:0]      r_grant,     w_grant_nxt;
    logic [N_REQ-1:0]      r_done,      w_done_nxt;
    logic                  r_tick,      w_tick_nxt;
    logic                  r_busy;

    logic [N_REQ-1:0]      w_win;
    logic [IDX_W-1:0]      w_win_idx;
    logic [DUR_W-1:0]      w_win_dur;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req     (req),
        .last    (r_last),
        .win     (w_win),
        .win_idx (w_win_idx)
    );

    assign w_win_dur = dur[int'(w_win_idx)*DUR_W +: DUR_W];

    always_comb begin
        w_state_nxt     = r_state;
        w_prescale_nxt  = r_prescale;
        w_remaining_nxt = r_remaining;
        w_last_nxt      = r_last;
        w_grant_nxt     = r_grant;
        w_done_nxt      = '0;
        w_tick_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_grant_nxt = '0;
                if (|req) begin
                    w_last_nxt      = w_win_idx;
                    w_remaining_nxt = w_win_dur;
                    w_prescale_nxt  = '0;
                    if (w_win_dur != '0) begin
                        w_state_nxt = ST_RUN;
                        w_grant_nxt = w_win;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = w_win;
                    end
                end
            end

            ST_RUN: begin
                // Owner withdrawing wins over a coincident final wrap: no tick, no done.
                if ((req & r_grant) == '0) begin
                    w_state_nxt    = ST_IDLE;
                    w_grant_nxt    = '0;
                    w_prescale_nxt = '0;
                end else if (r_prescale == PRESCALE_LAST) begin
                    w_prescale_nxt  = '0;
                    w_tick_nxt      = 1'b1;
                    w_remaining_nxt = r_remaining - DUR_W'(1);
                    if (r_remaining == DUR_W'(1)) begin
                        w_state_nxt = ST_DONE;
                        w_grant_nxt = '0;
                        w_done_nxt  = r_grant;
                    end
                end else begin
                    w_prescale_nxt = r_prescale + PRESCALE_W'(1);
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_prescale  <= '0;
            r_remaining <= '0;
            r_last      <= LAST_RESET;
            r_grant     <= '0;
            r_done      <= '0;
            r_tick      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prescale  <= w_prescale_nxt;
            r_remaining <= w_remaining_nxt;
            r_last      <= w_last_nxt;
            r_grant     <= w_grant_nxt;
            r_done      <= w_done_nxt;
            r_tick      <= w_tick_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign grant = r_grant;
    assign done  = r_done;
    assign tick  = r_tick;
    assign busy  = r_busy;

endmodule

// File: tb/tb_delay_arbiter.sv
// Self-checking bench: a cycle-level behavioural model of ownership windows drives
// a per-cycle compare, plus directed scenarios with hand-computed expectations.
module tb_delay_arbiter;

    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int P    = 4;
    localparam int DW_B = 12;
    localparam int P_B  = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_a = '0;
    logic [N*DW-1:0] dur_a = '0;
    logic [N-1:0]    grant_a, done_a;
    logic            tick_a, busy_a;

    logic [N-1:0]      req_b = '0;
    logic [N*DW_B-1:0] dur_b = '0;
    logic [N-1:0]      grant_b, done_b;
    logic              tick_b, busy_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    delay_arbiter #(.N_REQ(N), .DUR_W(DW), .PRESCALE(P)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .dur(dur_a),
        .grant(grant_a), .done(done_a), .tick(tick_a), .busy(busy_a)
    );

    delay_arbiter #(.N_REQ(N), .DUR_W(DW_B), .PRESCALE(P_B)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .dur(dur_b),
        .grant(grant_b), .done(done_b), .tick(tick_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    // Behavioural model: tracks who owns the timebase and how many cycles remain.
    int           m_mode;     // 0 free, 1 owned, 2 completion cycle
    int           m_owner, m_last, m_left, m_elapsed, m_w, m_d;
    logic [N-1:0] m_done;
    logic         m_tick;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_owner = 0; m_last = N - 1; m_left = 0; m_elapsed = 0;
            m_done = '0; m_tick = 1'b0;
        end else begin
            m_done = '0;
            m_tick = 1'b0;
            case (m_mode)
                0: if (req_a != '0) begin
                    m_w = -1;
                    for (int k = 1; k <= N; k++)
                        if (m_w < 0 && req_a[(m_last + k) % N]) m_w = (m_last + k) % N;
                    m_last = m_w;
                    m_d = int'(dur_a[m_w*DW +: DW]);
                    if (m_d == 0) begin
                        m_mode = 2;
                        m_done = N'(1 << m_w);
                    end else begin
                        m_mode = 1; m_owner = m_w; m_left = m_d * P; m_elapsed = 0;
                    end
                end
                1: if (!req_a[m_owner]) begin
                    m_mode = 0;
                end else begin
                    m_elapsed++;
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = 2;
                        m_done = N'(1 << m_owner);
                        m_tick = 1'b1;
                    end else if (m_elapsed % P == 0) begin
                        m_tick = 1'b1;
                    end
                end
                default: m_mode = 0;
            endcase
        end
    end

    int c_grant = 0, c_tick = 0, c_done = 0, c_busy = 0;
    logic [N-1:0] exp_grant;
    logic         exp_busy;

    always @(negedge clk) begin
        if (!rst) begin
            exp_grant = (m_mode == 1) ? N'(1 << m_owner) : '0;
            exp_busy  = (m_mode != 0);
            check("cycle {grant,done,tick,busy}",
                  32'({grant_a, done_a, tick_a, busy_a}),
                  32'({exp_grant, m_done, m_tick, exp_busy}));
            if (grant_a != '0) c_grant++;
            if (tick_a)        c_tick++;
            if (done_a != '0)  c_done++;
            if (busy_a)        c_busy++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grant(input string name, output logic [N-1:0] g);
        g = '0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (grant_a != '0) begin
                g = grant_a;
                return;
            end
        end
        fail_timeout(name);
    endtask

    task automatic wait_done(input string name, output logic [N-1:0] d);
        d = '0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (done_a != '0) begin
                d = done_a;
                return;
            end
        end
        fail_timeout(name);
    endtask

    initial begin
        logic [N-1:0] g, d;
        int s_grant, s_tick, s_done, s_busy;
        int b_grant, b_tick, b_busy;
        bit b_seen;

        repeat (3) step();
        rst = 1'b0;
        step();
        check("reset outputs", 32'({grant_a, done_a, tick_a, busy_a}), 32'h0);

        // Round robin, all durations one tick, requests re-raised after each done.
        dur_a = {N{16'd1}};
        for (int k = 0; k < 5; k++) begin
            req_a = 4'hF;
            wait_grant("rr grant", g);
            check("rr grant order", 32'(g), 32'(1 << (k % N)));
            wait_done("rr done", d);
            check("rr done owner", 32'(d), 32'(1 << (k % N)));
            req_a = '0;
            step();
        end

        // Single request, three ticks at prescale 4.
        step();
        s_grant = c_grant; s_tick = c_tick; s_done = c_done; s_busy = c_busy;
        dur_a[0*DW +: DW] = 16'd3;
        req_a = 4'b0001;
        wait_done("single done", d);
        check("single done vec", 32'(d), 32'h1);
        req_a = '0;
        step();
        step();
        check("single grant cycles", 32'(c_grant - s_grant), 32'd12);
        check("single tick pulses", 32'(c_tick - s_tick), 32'd3);
        check("single done cycles", 32'(c_done - s_done), 32'd1);
        check("single busy cycles", 32'(c_busy - s_busy), 32'd13);

        // Zero duration goes straight to completion.
        s_grant = c_grant; s_tick = c_tick;
        dur_a[2*DW +: DW] = 16'd0;
        req_a = 4'b0100;
        step();
        check("zero done", 32'(done_a), 32'h4);
        check("zero grant", 32'(grant_a), 32'h0);
        req_a = '0;
        step();
        check("zero done one cycle", 32'(done_a), 32'h0);
        step();
        check("zero no grant", 32'(c_grant - s_grant), 32'd0);
        check("zero no tick", 32'(c_tick - s_tick), 32'd0);

        // Abort at RUN cycle 6; requester 2 then wins over requester 0.
        s_done = c_done;
        dur_a[1*DW +: DW] = 16'd5;
        dur_a[2*DW +: DW] = 16'd2;
        req_a = 4'b0010;
        wait_grant("abort grant", g);
        check("abort owner", 32'(g), 32'h2);
        repeat (5) step();
        req_a = 4'b0101;
        step();
        check("abort grant drop", 32'(grant_a), 32'h0);
        step();
        check("after abort rr", 32'(grant_a), 32'h4);
        req_a = '0;
        step();
        step();
        check("abort no done", 32'(c_done - s_done), 32'd0);

        // Asynchronous reset mid-RUN restores the round-robin pointer.
        dur_a[0*DW +: DW] = 16'd5;
        req_a = 4'b0001;
        wait_grant("reset grant", g);
        check("reset pre owner", 32'(g), 32'h1);
        repeat (6) step();
        rst = 1'b1;
        #1;
        check("async reset outputs", 32'({grant_a, done_a, tick_a, busy_a}), 32'h0);
        req_a = 4'b0011;
        step();
        rst = 1'b0;
        step();
        check("post reset winner", 32'(grant_a), 32'h1);
        req_a = '0;
        repeat (3) step();

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            for (int r = 0; r < N; r++) begin
                if ($urandom_range(0, 15) == 0) req_a[r] = ~req_a[r];
                if ($urandom_range(0, 7) == 0) dur_a[r*DW +: DW] = DW'($urandom_range(0, 3));
            end
            step();
        end
        req_a = '0;
        repeat (4) step();

        // All-ones duration boundary on a narrower instance.
        b_grant = 0; b_tick = 0; b_busy = 0; b_seen = 1'b0;
        dur_b[0*DW_B +: DW_B] = '1;
        req_b = 4'b0001;
        for (int i = 0; i < 9000 && !b_seen; i++) begin
            step();
            if (grant_b != '0) b_grant++;
            if (tick_b)        b_tick++;
            if (busy_b)        b_busy++;
            if (done_b != '0) begin
                b_seen = 1'b1;
                check("max dur done vec", 32'(done_b), 32'h1);
            end
        end
        if (!b_seen) fail_timeout("max dur done");
        req_b = '0;
        check("max dur grant cycles", 32'(b_grant), 32'd8190);
        check("max dur ticks", 32'(b_tick), 32'd4095);
        check("max dur busy cycles", 32'(b_busy), 32'd8191);
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
